// File: rtl/dma_copy.sv
// dma_copy: single-channel memory-to-memory DMA engine.
//
// The CPU programs SRC/DST/COUNT through a four-word register window and
// starts the engine via CTRL. The engine then moves words in bursts of up to
// BURST words: it reads a burst into a local buffer and writes it back out.
// In fill mode SRC holds a constant pattern that is written COUNT times, and
// no reads are issued. Completion is signalled with a one-cycle interrupt.
//
// Ports
//   i_clock, i_reset             clock, synchronous active-high reset
//   i_request/i_rw/i_address/
//   i_wdata/o_rdata/o_ready      register slave (address bits [3:2] decoded)
//   o_bus_request/o_bus_rw/
//   o_bus_address/o_bus_wdata/
//   i_bus_ready/i_bus_rdata      bus master towards the arbiter's DMA port
//   o_busy                       transfer in progress (start+1 .. DONE)
//   o_interrupt                  one-cycle completion pulse
module dma_copy #(
  parameter int BURST = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic        o_busy,
  output logic        o_interrupt
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_nx;

  logic [31:0] src, dst, count;
  logic        fill;
  logic [CNT_W-1:0] len, idx;
  logic [31:0] buffer [BURST];
  logic [31:0] reg_view;
  logic        wr_take, start, beat, last;
  logic        unused_addr;

  function automatic logic [CNT_W-1:0] burst_len(input logic [31:0] words);
    if (words >= 32'(BURST)) return CNT_W'(BURST);
    return CNT_W'(words);
  endfunction

  assign unused_addr = ^{i_address[31:4], i_address[1:0]};

  // A slave write lands on the edge that raises o_ready; all writes are
  // dropped while a transfer is running, so the programmed values are safe.
  assign wr_take = i_request & ~o_ready & i_rw & (state == IDLE);
  assign start   = wr_take & (i_address[3:2] == 2'd3) & i_wdata[0];
  assign beat    = o_bus_request & i_bus_ready;
  assign last    = (idx == len - CNT_W'(1));

  assign o_busy      = (state != IDLE);
  assign o_interrupt = (state == DONE);

  always_comb begin
    reg_view = 32'd0;
    case (i_address[3:2])
      2'd0:    reg_view = src;
      2'd1:    reg_view = dst;
      2'd2:    reg_view = count;
      default: reg_view = {30'd0, fill, o_busy};
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (count == 32'd0)  state_nx = DONE;
          else if (i_wdata[1]) state_nx = WR;
          else                 state_nx = RD;
        end
      end
      RD: begin
        if (beat && last) state_nx = WR;
      end
      WR: begin
        if (beat && last) begin
          if (count == 32'd1) state_nx = DONE;
          else if (fill)      state_nx = WR;
          else                state_nx = RD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Staging buffer holds data only, so it is left out of reset.
  always_ff @(posedge i_clock) begin
    if (state == RD && beat) buffer[idx[IDX_W-1:0]] <= i_bus_rdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rdata       <= 32'd0;
      o_ready       <= 1'b0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= 32'd0;
      o_bus_wdata   <= 32'd0;
      src           <= 32'd0;
      dst           <= 32'd0;
      count         <= 32'd0;
      fill          <= 1'b0;
      len           <= '0;
      idx           <= '0;
    end else begin
      o_ready <= i_request;
      if (i_request && !i_rw) o_rdata <= reg_view;

      if (wr_take) begin
        case (i_address[3:2])
          2'd0:    src   <= i_wdata;
          2'd1:    dst   <= i_wdata;
          2'd2:    count <= i_wdata;
          default: fill  <= i_wdata[1];
        endcase
      end
      if (start) begin
        len <= burst_len(count);
        idx <= '0;
      end

      // A request is raised only when none is outstanding; after each
      // accepted beat the request drops, giving one idle cycle per beat.
      case (state)
        RD: begin
          if (!o_bus_request) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= src;
          end else if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            src           <= src + 32'd4;
            idx           <= last ? '0 : idx + CNT_W'(1);
          end
        end
        WR: begin
          if (!o_bus_request) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b1;
            o_bus_address <= dst;
            o_bus_wdata   <= fill ? src : buffer[idx[IDX_W-1:0]];
          end else if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            dst           <= dst + 32'd4;
            if (count != 32'd0) count <= count - 32'd1;
            if (last) begin
              idx <= '0;
              len <= burst_len(count - 32'd1);
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: each transfer's expected bus beats are
// generated from the register values, a responder process models the bus
// with random ready latency, and a monitor pops and compares every beat.
module tb_dma_copy;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, rw;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        bus_rw, bus_req, bus_ready;
  logic [31:0] bus_addr, bus_rdata, bus_wdata;
  logic        busy, irq;

  always #5 clk = ~clk;

  dma_copy #(.BURST(BURST)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_request(req), .i_rw(rw), .i_address(address), .i_wdata(wdata),
    .o_rdata(rdata), .o_ready(ready),
    .o_bus_rw(bus_rw), .o_bus_request(bus_req), .i_bus_ready(bus_ready),
    .o_bus_address(bus_addr), .i_bus_rdata(bus_rdata), .o_bus_wdata(bus_wdata),
    .o_busy(busy), .o_interrupt(irq)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t expq[$];
  int total = 0;
  int bad = 0;
  int n_bus = 0;
  int n_irq = 0;
  int n_busy = 0;
  int minlat = 0;
  int maxlat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus memory contents: a small table of 0xA0.. at 0x100 and a hash elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h200) return 32'hA0 + ((a - 32'h100) >> 2);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Reference: split COUNT into bursts of min(BURST, remaining); each burst
  // is n reads followed by n writes (writes only, of the pattern, in fill).
  function automatic void expect_transfer(input logic [31:0] src, input logic [31:0] dst,
                                          input logic [31:0] count, input logic fill);
    logic [31:0] rem;
    logic [31:0] s;
    logic [31:0] d;
    int n;
    beat_t b;
    rem = count;
    s = src;
    d = dst;
    while (rem != 0) begin
      n = (rem < 32'(BURST)) ? int'(rem) : BURST;
      if (!fill) begin
        for (int i = 0; i < n; i++) begin
          b.rw = 1'b0;
          b.addr = s + 32'(4 * i);
          b.data = rom_word(b.addr);
          expq.push_back(b);
        end
      end
      for (int i = 0; i < n; i++) begin
        b.rw = 1'b1;
        b.addr = d + 32'(4 * i);
        b.data = fill ? src : rom_word(s + 32'(4 * i));
        expq.push_back(b);
      end
      if (!fill) s = s + 32'(4 * n);
      d = d + 32'(4 * n);
      rem = rem - 32'(n);
    end
  endfunction

  // Bus responder: grants after a random latency, checks the request is
  // held stable while stalled and that one idle cycle separates beats.
  initial begin
    bit active;
    bit gap;
    int left;
    logic h_rw;
    logic [31:0] h_addr, h_wdata;
    active = 0;
    gap = 0;
    left = 0;
    h_rw = 0;
    h_addr = 0;
    h_wdata = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ready = 1'b0;
        active = 0;
        gap = 0;
      end else if (bus_ready) begin
        bus_ready = 1'b0;
        active = 0;
        check("req_drop", 32'(bus_req), 32'd0);
        gap = (expq.size() > 0);
      end else begin
        if (gap) begin
          gap = 0;
          check("idle_gap", 32'(bus_req), 32'd1);
        end
        if (active) begin
          check("stall_req", 32'(bus_req), 32'd1);
          check("stall_rw", 32'(bus_rw), 32'(h_rw));
          check("stall_addr", bus_addr, h_addr);
          if (h_rw) check("stall_wdata", bus_wdata, h_wdata);
        end else if (bus_req) begin
          active = 1;
          h_rw = bus_rw;
          h_addr = bus_addr;
          h_wdata = bus_wdata;
          left = $urandom_range(maxlat, minlat);
        end
        if (active) begin
          if (left == 0) begin
            bus_ready = 1'b1;
            bus_rdata = h_rw ? 32'd0 : rom_word(h_addr);
          end else begin
            left--;
          end
        end
      end
    end
  end

  // Monitor: every beat about to be accepted is compared with the scoreboard.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (busy) n_busy++;
        if (irq) n_irq++;
        if (bus_req && bus_ready) begin
          n_bus++;
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_bus: got rw=%0d addr=%h want no beat", bus_rw, bus_addr);
          end else begin
            b = expq.pop_front();
            check("bus_rw", 32'(bus_rw), 32'(b.rw));
            check("bus_addr", bus_addr, b.addr);
            if (b.rw) check("bus_wdata", bus_wdata, b.data);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_access(input logic w, input logic [1:0] r, input logic [31:0] d,
                            output logic [31:0] q);
    int k;
    k = 0;
    req = 1'b1;
    rw = w;
    address = {28'd0, r, 2'b00};
    wdata = d;
    tick();
    while (!ready && k < 10) begin
      tick();
      k++;
    end
    check("slave_ready", 32'(ready), 32'd1);
    q = rdata;
    req = 1'b0;
    rw = 1'b0;
    tick();
  endtask

  task automatic reg_write(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    reg_access(1'b1, r, d, q);
  endtask

  task automatic reg_read(input logic [1:0] r, output logic [31:0] q);
    reg_access(1'b0, r, 32'd0, q);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic run_transfer(input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] count, input logic fill);
    logic [31:0] q;
    int irq0;
    irq0 = n_irq;
    reg_write(2'd0, src);
    reg_write(2'd1, dst);
    reg_write(2'd2, count);
    expect_transfer(src, dst, count, fill);
    reg_write(2'd3, {30'd0, fill, 1'b1});
    wait_idle(5000);
    check("irq_count", 32'(n_irq - irq0), 32'd1);
    check("beats_left", 32'(expq.size()), 32'd0);
    reg_read(2'd2, q);
    check("count_end", q, 32'd0);
    reg_read(2'd1, q);
    check("dst_end", q, dst + (count << 2));
    reg_read(2'd0, q);
    check("src_end", q, fill ? src : src + (count << 2));
    reg_read(2'd3, q);
    check("ctrl_end", q, 32'({fill, 1'b0}));
  endtask

  initial begin
    logic [31:0] q;
    int busy0, bus0, irq0, k;
    rst = 1'b1;
    req = 1'b0;
    rw = 1'b0;
    address = 32'd0;
    wdata = 32'd0;
    repeat (3) tick();
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_rw", 32'(bus_rw), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), q);
      check("rst_reg", q, 32'd0);
    end

    // Plain copy, bursts of 4 then 2.
    minlat = 0;
    maxlat = 2;
    run_transfer(32'h0000_0100, 32'h1000_0000, 32'd6, 1'b0);

    // Fill mode: writes only.
    run_transfer(32'hDEAD_BEEF, 32'h1000_0040, 32'd3, 1'b1);

    // Zero-length start: one busy cycle, interrupt, no bus traffic.
    busy0 = n_busy;
    bus0 = n_bus;
    run_transfer(32'h0000_0100, 32'h1000_0080, 32'd0, 1'b0);
    check("zero_busy_cycles", 32'(n_busy - busy0), 32'd1);
    check("zero_bus_beats", 32'(n_bus - bus0), 32'd0);

    // Random transfers under random 0..5 cycle stalls.
    minlat = 0;
    maxlat = 5;
    for (int t = 0; t < 5; t++) begin
      run_transfer(32'h100 + 32'($urandom_range(0, 40)) * 4,
                   32'h1000_0000 + 32'($urandom_range(0, 1023)) * 4,
                   32'($urandom_range(1, 11)), 1'($urandom_range(0, 1)));
    end

    // Writes while busy are ignored.
    minlat = 1;
    maxlat = 3;
    irq0 = n_irq;
    reg_write(2'd0, 32'h0000_0100);
    reg_write(2'd1, 32'h1000_0100);
    reg_write(2'd2, 32'd8);
    expect_transfer(32'h0000_0100, 32'h1000_0100, 32'd8, 1'b0);
    reg_write(2'd3, 32'd1);
    reg_write(2'd1, 32'h1234_5678);
    reg_write(2'd3, 32'd1);
    reg_read(2'd3, q);
    check("ctrl_busy", q, 32'd1);
    wait_idle(5000);
    check("prot_irq", 32'(n_irq - irq0), 32'd1);
    check("prot_beats_left", 32'(expq.size()), 32'd0);
    reg_read(2'd1, q);
    check("prot_dst_end", q, 32'h1000_0120);

    // Destination wraps past the top of the address space.
    minlat = 0;
    maxlat = 2;
    run_transfer(32'h0000_0120, 32'hFFFF_FFFC, 32'd2, 1'b0);

    // Same transfer aborted by reset during the second read.
    minlat = 3;
    maxlat = 4;
    irq0 = n_irq;
    bus0 = n_bus;
    reg_write(2'd0, 32'h0000_0120);
    reg_write(2'd1, 32'hFFFF_FFFC);
    reg_write(2'd2, 32'd2);
    expect_transfer(32'h0000_0120, 32'hFFFF_FFFC, 32'd2, 1'b0);
    reg_write(2'd3, 32'd1);
    k = 0;
    while (!(n_bus == bus0 + 1 && bus_req) && k < 200) begin
      tick();
      k++;
    end
    check("second_read_seen", 32'(n_bus - bus0), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_req", 32'(bus_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", bus_addr, 32'd0);
    rst = 1'b0;
    expq.delete();
    repeat (5) tick();
    check("abort_irq", 32'(n_irq - irq0), 32'd0);
    for (int r = 0; r < 4; r++) begin
      reg_read(2'(r), q);
      check("abort_reg", q, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
